// File: rtl/npu_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_dma_pkg
// Brief    : Shared opcodes, header field positions and FSM encodings for the
//            DMA path responder.
// Revision : 1.0 - initial release
// ============================================================================
package npu_dma_pkg;

   localparam logic [7:0] OP_WRITE = 8'h03;
   localparam logic [7:0] OP_READ  = 8'h01;

   localparam int HDR_ADDR_LSB = 16;
   localparam int HDR_ADDR_MSB = 55;
   localparam int HDR_LEN_LSB  = 56;
   localparam int HDR_LEN_MSB  = 71;
   localparam int HDR_OP_LSB   = 72;
   localparam int HDR_OP_MSB   = 79;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_HDR   = 3'd2,
      ST_WR    = 3'd3,
      ST_RD    = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/npu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : npu_sync_fifo
// Brief    : Single-clock FIFO; a push into a full FIFO is accepted when a pop
//            happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module npu_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign pop_data = r_mem[r_rd_ptr];
   assign full     = (r_count == (c_PTR_W+1)'(DEPTH));
   assign empty    = (r_count == '0);
   assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/dma_path_responder.sv
`default_nettype none
// ============================================================================
// Module   : dma_path_responder
// Brief    : Link-side DMA responder: grants a request, parses the command
//            header and moves payload between the link and host memory.
// Revision : 1.0 - initial release
// ============================================================================
module dma_path_responder
   import npu_dma_pkg::*;
#(
   parameter int ADDR_W        = 40,
   parameter int DATA_W        = 128,
   parameter int LEN_W         = 16,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ls_req,
   output logic              ls_resp,
   input  logic              ls_write_valid,
   input  logic [DATA_W-1:0] ls_write_data,
   output logic              ls_write_ready,
   output logic              ls_read_valid,
   output logic [DATA_W-1:0] ls_read_data,
   input  logic              ls_read_ready,
   output logic              mem_req_valid,
   output logic              mem_req_rwn,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              busy,
   output logic              cmd_err
);

   localparam int c_STEP_SHIFT = $clog2(DATA_W/8);
   localparam int c_CNT_W      = LEN_W + 1;
   localparam int c_FC_W       = $clog2(RD_FIFO_DEPTH) + 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [LEN_W-1:0]    r_len;
   logic [c_CNT_W-1:0]  r_cnt;       // write beats accepted, or read requests issued
   logic [c_CNT_W-1:0]  r_popped;
   logic [c_FC_W-1:0]   r_outstanding;
   logic                r_cmd_err;

   logic [c_CNT_W-1:0]  w_len_ext;
   logic [ADDR_W-1:0]   w_addr;
   logic [ADDR_W-1:0]   w_hdr_addr;
   logic [LEN_W-1:0]    w_hdr_len;
   logic [7:0]          w_hdr_op;
   logic                w_hdr_fire;
   logic                w_wr_fire;
   logic                w_rd_issue;
   logic                w_rd_fire;
   logic                w_push;
   logic                w_pop;
   logic                w_credit_ok;
   logic [c_FC_W:0]     w_inflight;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [c_FC_W-1:0]   w_fifo_count;
   logic [DATA_W-1:0]   w_fifo_head;

   assign w_hdr_addr = ADDR_W'(ls_write_data[HDR_ADDR_MSB:HDR_ADDR_LSB]);
   assign w_hdr_len  = LEN_W'(ls_write_data[HDR_LEN_MSB:HDR_LEN_LSB]);
   assign w_hdr_op   = ls_write_data[HDR_OP_MSB:HDR_OP_LSB];

   assign w_len_ext  = {1'b0, r_len};
   assign w_addr     = r_base + (ADDR_W'(r_cnt) << c_STEP_SHIFT);

   assign w_hdr_fire = (r_state == ST_HDR) && ls_write_valid;
   assign w_wr_fire  = (r_state == ST_WR) && ls_write_valid && mem_req_ready;
   assign w_rd_fire  = w_rd_issue && mem_req_ready;
   assign w_pop      = ls_read_valid && ls_read_ready;
   // Responses with nothing outstanding belong to a command killed by reset.
   assign w_push     = mem_rsp_valid && (r_outstanding != '0);

   assign w_inflight  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
   assign w_credit_ok = !w_fifo_full && (w_inflight < (c_FC_W+1)'(RD_FIFO_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      ls_resp        = 1'b0;
      ls_write_ready = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_rwn    = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      w_rd_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ls_req) w_state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            ls_resp     = 1'b1;
            w_state_nxt = ST_HDR;
         end
         ST_HDR: begin
            ls_write_ready = 1'b1;
            if (ls_write_valid) begin
               if (w_hdr_op == OP_WRITE) begin
                  w_state_nxt = (w_hdr_len == '0) ? ST_DONE : ST_WR;
               end else if (w_hdr_op == OP_READ) begin
                  w_state_nxt = (w_hdr_len == '0) ? ST_DONE : ST_RD;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_WR: begin
            mem_req_valid  = ls_write_valid;
            ls_write_ready = mem_req_ready;
            mem_req_addr   = w_addr;
            mem_req_wdata  = ls_write_data;
            if (w_wr_fire && ((r_cnt + c_CNT_W'(1)) == w_len_ext)) w_state_nxt = ST_DONE;
         end
         ST_RD: begin
            w_rd_issue    = (r_cnt < w_len_ext) && w_credit_ok;
            mem_req_valid = w_rd_issue;
            mem_req_rwn   = w_rd_issue;
            mem_req_addr  = w_rd_issue ? w_addr : '0;
            if (w_pop && ((r_popped + c_CNT_W'(1)) == w_len_ext)) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base        <= '0;
         r_len         <= '0;
         r_cnt         <= '0;
         r_popped      <= '0;
         r_outstanding <= '0;
         r_cmd_err     <= 1'b0;
      end else begin
         if (w_hdr_fire) begin
            r_base   <= w_hdr_addr;
            r_len    <= w_hdr_len;
            r_cnt    <= '0;
            r_popped <= '0;
            if ((w_hdr_op != OP_WRITE) && (w_hdr_op != OP_READ)) r_cmd_err <= 1'b1;
         end
         if (w_wr_fire || w_rd_fire) r_cnt <= r_cnt + c_CNT_W'(1);
         if (w_pop) r_popped <= r_popped + c_CNT_W'(1);
         case ({w_rd_fire, w_push})
            2'b10:   r_outstanding <= r_outstanding + c_FC_W'(1);
            2'b01:   r_outstanding <= r_outstanding - c_FC_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   npu_sync_fifo #(
      .DEPTH (RD_FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_rd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (mem_rsp_data),
      .pop       (w_pop),
      .pop_data  (w_fifo_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (w_fifo_count)
   );

   assign ls_read_valid = !w_fifo_empty;
   assign ls_read_data  = w_fifo_empty ? '0 : w_fifo_head;
   assign busy          = (r_state != ST_IDLE);
   assign cmd_err       = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_path_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_path_responder
// Brief    : Directed self-checking bench with a latency-configurable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_path_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ls_req = 1'b0;
   logic         ls_resp;
   logic         ls_write_valid = 1'b0;
   logic [127:0] ls_write_data = '0;
   logic         ls_write_ready;
   logic         ls_read_valid;
   logic [127:0] ls_read_data;
   logic         ls_read_ready = 1'b1;
   logic         mem_req_valid;
   logic         mem_req_rwn;
   logic [39:0]  mem_req_addr;
   logic [127:0] mem_req_wdata;
   logic         mem_req_ready = 1'b1;
   logic         mem_rsp_valid = 1'b0;
   logic [127:0] mem_rsp_data = '0;
   logic         busy;
   logic         cmd_err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int mem_lat = 1;
   int mem_req_count = 0;

   typedef struct { int due; logic [127:0] data; } rsp_t;
   rsp_t         rsp_q[$];
   logic [39:0]  wr_addr_q[$];
   logic [127:0] wr_data_q[$];
   logic [39:0]  rd_addr_q[$];
   logic [127:0] rdret_q[$];

   dma_path_responder dut (
      .clk(clk), .rst(rst), .ls_req(ls_req), .ls_resp(ls_resp),
      .ls_write_valid(ls_write_valid), .ls_write_data(ls_write_data),
      .ls_write_ready(ls_write_ready), .ls_read_valid(ls_read_valid),
      .ls_read_data(ls_read_data), .ls_read_ready(ls_read_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rwn(mem_req_rwn),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] mem_val(input logic [39:0] a);
      return {48'hFEED_FACE_CAFE, ~a, a};
   endfunction

   function automatic logic [127:0] mk_hdr(input logic [7:0] op, input logic [39:0] a,
                                           input logic [15:0] len);
      return {48'h5A5A_1234_9876, op, len, a, 4'hF, 12'hABC};
   endfunction

   function automatic logic [127:0] pay(input int tag, input int i);
      return {32'(tag), 32'(i), ~32'(tag), ~32'(i)};
   endfunction

   // Memory model: in-order read returns after mem_lat cycles; handshakes logged away from the edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = rsp_q[0].data;
         void'(rsp_q.pop_front());
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req_valid && mem_req_ready) begin
            mem_req_count++;
            if (mem_req_rwn) begin
               rd_addr_q.push_back(mem_req_addr);
               rsp_q.push_back('{cyc + mem_lat, mem_val(mem_req_addr)});
            end else begin
               wr_addr_q.push_back(mem_req_addr);
               wr_data_q.push_back(mem_req_wdata);
            end
         end
         if (ls_read_valid && ls_read_ready) rdret_q.push_back(ls_read_data);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rdret_q.delete();
      mem_req_count = 0;
   endtask

   // Request, wait for grant, present the header; ok=0 if grant or header acceptance never comes.
   task automatic start_cmd(input logic [7:0] op, input logic [39:0] a, input logic [15:0] len,
                            output bit ok);
      ok = 1'b0;
      ls_req = 1'b1;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         ok = ls_resp;
      end
      tick();
      ls_req = 1'b0;
      if (ok) begin
         ls_write_valid = 1'b1;
         ls_write_data  = mk_hdr(op, a, len);
         @(negedge clk);
         ok = ls_write_ready;
         tick();
         ls_write_valid = 1'b0;
         ls_write_data  = '0;
      end
   endtask

   task automatic send_beats(input int tag, input int n, output bit ok);
      ok = 1'b1;
      for (int b = 0; b < n; b++) begin
         bit acc;
         acc = 1'b0;
         ls_write_valid = 1'b1;
         ls_write_data  = pay(tag, b);
         for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = ls_write_ready;
            tick();
         end
         if (!acc) ok = 1'b0;
      end
      ls_write_valid = 1'b0;
      ls_write_data  = '0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         ok = !busy;
      end
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      @(negedge clk);
      tests++;
      if ({busy, ls_resp, ls_write_ready, ls_read_valid, mem_req_valid, mem_req_rwn, cmd_err} !== 7'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b want 0000000",
            {busy, ls_resp, ls_write_ready, ls_read_valid, mem_req_valid, mem_req_rwn, cmd_err});
      end
      tests++;
      if (mem_req_addr !== 40'h0 || mem_req_wdata !== 128'h0 || ls_read_data !== 128'h0) begin
         fails++; $display("FAIL reset_data: addr %h wdata %h rdata %h want all 0",
            mem_req_addr, mem_req_wdata, ls_read_data);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_basic();
      bit ok, ok2, ok3;
      logic [39:0] exp_a [2];
      exp_a[0] = 40'h10_0000_0000; exp_a[1] = 40'h10_0000_0010;
      clear_logs();
      start_cmd(8'h03, 40'h10_0000_0000, 16'd2, ok);
      send_beats(1, 2, ok2);
      wait_idle(ok3);
      tests++;
      if ({ok, ok2, ok3} !== 3'b111) begin
         fails++; $display("FAIL wr_basic_flow: hdr/payload/idle %b want 111", {ok, ok2, ok3});
      end
      tests++;
      if (wr_addr_q.size() != 2 || rd_addr_q.size() != 0) begin
         fails++; $display("FAIL wr_basic_count: writes %0d reads %0d want 2 0",
            wr_addr_q.size(), rd_addr_q.size());
      end
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (i >= wr_addr_q.size() || wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== pay(1, i)) begin
            fails++; $display("FAIL wr_basic_beat%0d: addr %h data %h want %h %h", i,
               (i < wr_addr_q.size()) ? wr_addr_q[i] : 40'hx, (i < wr_data_q.size()) ? wr_data_q[i] : 128'hx,
               exp_a[i], pay(1, i));
         end
      end
   endtask

   task automatic test_read_wrap();
      bit ok, ok2;
      logic [39:0] exp_a [3];
      exp_a[0] = 40'hFF_FFFF_FFF0; exp_a[1] = 40'h00_0000_0000; exp_a[2] = 40'h00_0000_0010;
      clear_logs();
      mem_lat = 3;
      start_cmd(8'h01, 40'hFF_FFFF_FFF0, 16'd3, ok);
      wait_idle(ok2);
      tests++;
      if ({ok, ok2} !== 2'b11 || rd_addr_q.size() != 3 || rdret_q.size() != 3) begin
         fails++; $display("FAIL rd_wrap_flow: ok %b reads %0d beats %0d want 11 3 3",
            {ok, ok2}, rd_addr_q.size(), rdret_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= rdret_q.size() || rd_addr_q[i] !== exp_a[i] || rdret_q[i] !== mem_val(exp_a[i])) begin
            fails++; $display("FAIL rd_wrap_beat%0d: addr %h data %h want %h %h", i,
               (i < rd_addr_q.size()) ? rd_addr_q[i] : 40'hx, (i < rdret_q.size()) ? rdret_q[i] : 128'hx,
               exp_a[i], mem_val(exp_a[i]));
         end
      end
      mem_lat = 1;
   endtask

   task automatic test_read_backpressure();
      bit ok, ok2;
      logic [39:0] base;
      base = 40'h00_0123_4000;
      clear_logs();
      mem_lat = 2;
      ls_read_ready = 1'b0;
      start_cmd(8'h01, base, 16'd8, ok);
      repeat (20) tick();
      @(negedge clk);
      tests++;
      if (!ok || rd_addr_q.size() > 4 || rd_addr_q.size() == 0 || rdret_q.size() != 0 || !ls_read_valid) begin
         fails++; $display("FAIL rd_bp_stall: ok %b issued %0d delivered %0d valid %b want 1 1..4 0 1",
            ok, rd_addr_q.size(), rdret_q.size(), ls_read_valid);
      end
      tick();
      ls_read_ready = 1'b1;
      wait_idle(ok2);
      tests++;
      if (!ok2 || rd_addr_q.size() != 8 || rdret_q.size() != 8) begin
         fails++; $display("FAIL rd_bp_total: idle %b issued %0d delivered %0d want 1 8 8",
            ok2, rd_addr_q.size(), rdret_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         logic [39:0] ea;
         ea = base + 40'(16 * i);
         tests++;
         if (i >= rdret_q.size() || rdret_q[i] !== mem_val(ea)) begin
            fails++; $display("FAIL rd_bp_beat%0d: data %h want %h", i,
               (i < rdret_q.size()) ? rdret_q[i] : 128'hx, mem_val(ea));
         end
      end
      mem_lat = 1;
   endtask

   task automatic test_write_toggle();
      bit ok, ok2;
      int b, mism;
      logic [7:0] pat;
      pat = 8'b1011_0010;
      clear_logs();
      start_cmd(8'h03, 40'h00_0000_1000, 16'd4, ok);
      b = 0; mism = 0;
      for (int c = 0; c < 40 && b < 4; c++) begin
         mem_req_ready  = pat[c % 8];
         ls_write_valid = 1'b1;
         ls_write_data  = pay(4, b);
         @(negedge clk);
         if (ls_write_ready !== mem_req_ready) mism++;
         if (mem_req_ready) b++;
         tick();
      end
      ls_write_valid = 1'b0;
      mem_req_ready  = 1'b1;
      wait_idle(ok2);
      tests++;
      if (!ok || !ok2 || mism != 0) begin
         fails++; $display("FAIL wr_toggle_ready: ok %b idle %b ready mismatches %0d want 1 1 0", ok, ok2, mism);
      end
      tests++;
      if (wr_addr_q.size() != 4) begin
         fails++; $display("FAIL wr_toggle_count: writes %0d want 4", wr_addr_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= wr_addr_q.size() || wr_addr_q[i] !== 40'h00_0000_1000 + 40'(16 * i) ||
             wr_data_q[i] !== pay(4, i)) begin
            fails++; $display("FAIL wr_toggle_beat%0d: addr %h data %h want %h %h", i,
               (i < wr_addr_q.size()) ? wr_addr_q[i] : 40'hx, (i < wr_data_q.size()) ? wr_data_q[i] : 128'hx,
               40'h00_0000_1000 + 40'(16 * i), pay(4, i));
         end
      end
   endtask

   task automatic test_len_zero();
      for (int k = 0; k < 2; k++) begin
         bit ok;
         logic b_done, b_idle;
         clear_logs();
         start_cmd((k == 0) ? 8'h01 : 8'h03, 40'h00_0000_2000, 16'd0, ok);
         @(negedge clk);
         b_done = busy;
         tick();
         @(negedge clk);
         b_idle = busy;
         tick();
         tests++;
         if (!ok || b_done !== 1'b1 || b_idle !== 1'b0 || mem_req_count != 0) begin
            fails++; $display("FAIL len_zero_%s: ok %b busy %b->%b reqs %0d want 1 1->0 0",
               (k == 0) ? "rd" : "wr", ok, b_done, b_idle, mem_req_count);
         end
      end
   endtask

   task automatic test_bad_opcode();
      bit ok, ok2;
      clear_logs();
      start_cmd(8'h07, 40'h00_0000_3000, 16'd2, ok);
      wait_idle(ok2);
      tests++;
      if (!ok || !ok2 || cmd_err !== 1'b1 || mem_req_count != 0) begin
         fails++; $display("FAIL bad_op: ok %b idle %b cmd_err %b reqs %0d want 1 1 1 0",
            ok, ok2, cmd_err, mem_req_count);
      end
      start_cmd(8'h03, 40'h00_0000_3000, 16'd0, ok);
      wait_idle(ok2);
      tests++;
      if (cmd_err !== 1'b1) begin
         fails++; $display("FAIL bad_op_sticky: cmd_err %b want 1", cmd_err);
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok, ok2;
      clear_logs();
      mem_lat = 4;
      mem_req_ready = 1'b0;
      start_cmd(8'h01, 40'h00_0000_4000, 16'd4, ok);
      mem_req_ready = 1'b1;
      tick();
      tick();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      tests++;
      if (!ok || rd_addr_q.size() != 2 ||
          {busy, ls_resp, ls_write_ready, ls_read_valid, mem_req_valid, mem_req_rwn} !== 6'b0 ||
          ls_read_data !== 128'h0 || mem_req_addr !== 40'h0) begin
         fails++; $display("FAIL rst_mid_outputs: ok %b issued %0d ctrl %b rdata %h addr %h want 1 2 000000 0 0",
            ok, rd_addr_q.size(), {busy, ls_resp, ls_write_ready, ls_read_valid, mem_req_valid, mem_req_rwn},
            ls_read_data, mem_req_addr);
      end
      tick();
      rst = 1'b0;
      mem_req_ready = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      tests++;
      if (ls_read_valid !== 1'b0 || busy !== 1'b0 || rdret_q.size() != 0) begin
         fails++; $display("FAIL rst_mid_flush: read_valid %b busy %b delivered %0d want 0 0 0",
            ls_read_valid, busy, rdret_q.size());
      end
      tick();
      clear_logs();
      start_cmd(8'h01, 40'h00_0000_5000, 16'd1, ok);
      wait_idle(ok2);
      tests++;
      if (!ok || !ok2 || rd_addr_q.size() != 1 || rdret_q.size() != 1 ||
          rd_addr_q[0] !== 40'h00_0000_5000 || rdret_q[0] !== mem_val(40'h00_0000_5000)) begin
         fails++; $display("FAIL rst_mid_next: issued %0d delivered %0d data %h want 1 1 %h",
            rd_addr_q.size(), rdret_q.size(), (rdret_q.size() > 0) ? rdret_q[0] : 128'hx,
            mem_val(40'h00_0000_5000));
      end
      mem_lat = 1;
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_wrap();
      test_read_backpressure();
      test_write_toggle();
      test_len_zero();
      test_reset_mid_read();
      test_bad_opcode();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
